// File: rtl/poly_arith_read_sequencer.sv
// poly_arith_read_sequencer: interleaved A/B row read issuer for coefficient-wise poly add/sub/mult.
// Optional POLY_ARITH_SRC_CHECK_EN adds an err pulse for rejected starts (bad opcode or source index).
module poly_arith_read_sequencer #(
    parameter int LOGN         = 0,
    parameter int LOGQ         = 0,
    parameter int PE           = 0,
    parameter int NUM_POLY     = 2,
    parameter int DRAIN_CYCLES = 8,
    localparam int N  = 1 << LOGN,
    localparam int DR = (PE < 1) ? 1 : N / 2 / PE,
    localparam int D  = (DR < 1) ? 1 : DR,
    localparam int LD = $clog2(D),
    localparam int RW = (LD < 1) ? 1 : LD,
    localparam int AR = $clog2(NUM_POLY * D),
    localparam int AW = (AR < 1) ? 1 : AR,
    localparam int PR = $clog2(NUM_POLY),
    localparam int PW = (PR < 1) ? 1 : PR,
    // LOGQ only participates here so that it is referenced; it never changes the width
    localparam int CW = $clog2(DRAIN_CYCLES + 1) + ((LOGQ < 0) ? 1 : 0)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op_req,
    input  logic [PW-1:0] src_a,
    input  logic [PW-1:0] src_b,
    input  logic          swap_req,
    input  logic          stall,
    output logic [1:0]    opcode,
    output logic [AW-1:0] addr,
    output logic          valid,
    output logic          swap,
    output logic          busy,
`ifdef POLY_ARITH_SRC_CHECK_EN
    output logic          err,
`endif
    output logic          done
);
    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN} state_t;
    state_t        state, state_d;
    logic [RW-1:0] row, row_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW-1:0] src_a_q, src_b_q, src_a_d, src_b_d;
    logic [1:0]    opcode_d;
    logic [AW-1:0] addr_d;
    logic          valid_d, swap_d, busy_d, done_d, start_ok;
    // D is a power of two, so src*D+row is a shift and OR rather than a multiply
    function automatic logic [AW-1:0] row_addr(input logic [PW-1:0] src, input logic [RW-1:0] r);
        return (AW'(src) << LD) | AW'(r);
    endfunction
`ifdef POLY_ARITH_SRC_CHECK_EN
    logic err_d, src_bad;
    assign src_bad  = ({1'b0, src_a} >= (PW+1)'(NUM_POLY)) || ({1'b0, src_b} >= (PW+1)'(NUM_POLY));
    assign start_ok = start && op_req != 2'd0 && !src_bad;
`else
    assign start_ok = start && op_req != 2'd0;
`endif
    always_comb begin
        state_d  = state;
        row_d    = row;
        cnt_d    = cnt;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        opcode_d = opcode;
        addr_d   = addr;
        valid_d  = 1'b0;
        swap_d   = swap;
        busy_d   = busy;
        done_d   = 1'b0;
`ifdef POLY_ARITH_SRC_CHECK_EN
        err_d    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_ok) begin
                    opcode_d = op_req;
                    src_a_d  = src_a;
                    src_b_d  = src_b;
                    swap_d   = swap_req;
                    row_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ISSUE_A;
                end
`ifdef POLY_ARITH_SRC_CHECK_EN
                err_d = start && !start_ok;
`endif
            end
            ISSUE_A: begin
                if (!stall) begin
                    addr_d  = row_addr(src_a_q, row);
                    valid_d = 1'b1;
                    state_d = ISSUE_B;
                end
            end
            ISSUE_B: begin
                // stall is ignored here so an A row is always followed by its B row
                addr_d  = row_addr(src_b_q, row);
                valid_d = 1'b1;
                if (row == RW'(D - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end else begin
                    row_d   = row + 1'b1;
                    state_d = ISSUE_A;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    opcode_d = 2'd0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            cnt     <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            opcode  <= 2'd0;
            addr    <= '0;
            valid   <= 1'b0;
            swap    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef POLY_ARITH_SRC_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            row     <= row_d;
            cnt     <= cnt_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            opcode  <= opcode_d;
            addr    <= addr_d;
            valid   <= valid_d;
            swap    <= swap_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef POLY_ARITH_SRC_CHECK_EN
            err     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_poly_arith_read_sequencer.sv
// tb_poly_arith_read_sequencer: directed plus random stimulus checked against a per-cycle issue-count model.
module tb_poly_arith_read_sequencer;
    localparam int NUM_POLY = 3;
    localparam int DC       = 8;
    localparam int D        = 4;
    localparam int AW       = 4;
    localparam int PW       = 2;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, swap_req = 1'b0, stall = 1'b0;
    logic [1:0]    op_req = 2'd0;
    logic [PW-1:0] src_a = '0, src_b = '0;
    logic [1:0]    opcode;
    logic [AW-1:0] addr;
    logic          valid, swap, busy, done;
`ifdef POLY_ARITH_SRC_CHECK_EN
    logic          err;
    int            m_err = 0;
`endif
    int vectors = 0, miscompares = 0;
    int m_busy = 0, m_op = 0, m_addr = 0, m_valid = 0, m_swap = 0, m_done = 0;
    int m_sa = 0, m_sb = 0, m_issued = 0, m_left = 0;

    poly_arith_read_sequencer #(
        .LOGN(4), .LOGQ(16), .PE(2), .NUM_POLY(NUM_POLY), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op_req(op_req), .src_a(src_a), .src_b(src_b),
        .swap_req(swap_req), .stall(stall), .opcode(opcode), .addr(addr), .valid(valid),
        .swap(swap), .busy(busy),
`ifdef POLY_ARITH_SRC_CHECK_EN
        .err(err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Operation = 2*D row reads in A,B order; stall may only delay an A read; then DC idle cycles to done
    task automatic model_step();
        bit ok;
        if (rst) begin
            m_busy = 0; m_op = 0; m_addr = 0; m_valid = 0; m_swap = 0; m_done = 0;
`ifdef POLY_ARITH_SRC_CHECK_EN
            m_err = 0;
`endif
            return;
        end
        m_valid = 0;
        m_done  = 0;
`ifdef POLY_ARITH_SRC_CHECK_EN
        m_err   = 0;
`endif
        if (m_busy == 0) begin
            if (start) begin
                ok = op_req != 0;
`ifdef POLY_ARITH_SRC_CHECK_EN
                ok = ok && int'(src_a) < NUM_POLY && int'(src_b) < NUM_POLY;
                m_err = ok ? 0 : 1;
`endif
                if (ok) begin
                    m_busy = 1; m_op = int'(op_req); m_swap = int'(swap_req);
                    m_sa = int'(src_a); m_sb = int'(src_b); m_issued = 0;
                end
            end
        end else if (m_issued < 2 * D) begin
            if (m_issued % 2 == 1 || !stall) begin
                m_addr  = (((m_issued % 2 == 1) ? m_sb : m_sa) * D + m_issued / 2) % (1 << AW);
                m_valid = 1;
                m_issued++;
                if (m_issued == 2 * D) m_left = DC;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_busy = 0; m_op = 0;
            end
        end
    endtask

    task automatic cyc(input bit s, input int op, input int a, input int b, input bit sw, input bit st, input bit r);
        @(negedge clk);
        start = s; op_req = 2'(op); src_a = PW'(a); src_b = PW'(b); swap_req = sw; stall = st; rst = r;
        @(posedge clk);
        model_step();
        #1;
        check("opcode", int'(opcode), m_op);
        check("addr", int'(addr), m_addr);
        check("valid", int'(valid), m_valid);
        check("swap", int'(swap), m_swap);
        check("busy", int'(busy), m_busy);
        check("done", int'(done), m_done);
`ifdef POLY_ARITH_SRC_CHECK_EN
        check("err", int'(err), m_err);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 2, 0, 1, 0, 0, 0);
        idle(2 * D + DC + 2);
        cyc(1, 3, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        idle(2 * D + DC);
        cyc(1, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 2, 0, 0, 1, 1, 0);
        idle(2 * D + DC);
        cyc(1, 0, 0, 1, 0, 0, 0);
        idle(3);
        cyc(1, 2, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 2, 1, 0, 0, 0, 0);
        idle(2 * D + DC + 1);
        cyc(1, 2, 0, 3, 0, 0, 0);
        idle(2 * D + DC + 1);
        for (int i = 0; i < 2500; i++)
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
